// File: rtl/pc_seq_ctrl_pkg.sv
// Shared types and constants for the PC sequencing controller and the decoder
// that reuses its branch-condition evaluator.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } seq_state_e;

    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_NE = 3'd1;
    localparam logic [2:0] COND_CS = 3'd2;
    localparam logic [2:0] COND_CC = 3'd3;
    localparam logic [2:0] COND_AL = 3'd4;

    localparam int BOOT_CNT_W     = 8;
    localparam int STALL_CNT_W    = 8;
    localparam int REDIRECT_CNT_W = 16;

    // True when two or more bits of the redirect request vector are set.
    function automatic logic multi_hot4(input logic [3:0] v);
        return ((v & (v - 4'd1)) != 4'd0);
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Decoder/flag-side requests into the sequencer and the PC-control strobes out of it.
interface pc_seq_ctrl_if;
    logic        br_req;
    logic [2:0]  br_cond;
    logic        flag_z;
    logic        flag_c;
    logic        jmp_req;
    logic        jal_rm_req;
    logic        jr_req;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;

    logic        PC_EN;
    logic        PC_SE_flag;
    logic        JMP_flag;
    logic        JAL_Rm_flag;
    logic        JR_flag;
    logic        halted;
    logic        fault;
    logic        multi_req_err;
    logic [15:0] redirect_cnt;

    modport master (
        output br_req, br_cond, flag_z, flag_c, jmp_req, jal_rm_req, jr_req,
               halt_req, resume, imem_ready,
        input  PC_EN, PC_SE_flag, JMP_flag, JAL_Rm_flag, JR_flag, halted, fault,
               multi_req_err, redirect_cnt
    );

    modport slave (
        input  br_req, br_cond, flag_z, flag_c, jmp_req, jal_rm_req, jr_req,
               halt_req, resume, imem_ready,
        output PC_EN, PC_SE_flag, JMP_flag, JAL_Rm_flag, JR_flag, halted, fault,
               multi_req_err, redirect_cnt
    );
endinterface

// File: rtl/pc_seq_ctrl_branch_cond_eval.sv
// Combinational branch-condition evaluator; codes 5..7 are never taken.
module branch_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       taken
);

    // Map condition code and flags onto a taken decision.
    always_comb begin
        taken = 1'b0;
        case (br_cond)
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_CS: taken = flag_c;
            COND_CC: taken = ~flag_c;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: fetch-state FSM, imem stall watchdog, one-hot PC
// source selection with fixed priority JR > JAL_Rm > JMP > PC_SE, redirect counting.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES   = 2,
    parameter int unsigned STALL_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          CLR,
    pc_seq_ctrl_if.slave  bus
);

    localparam logic [BOOT_CNT_W-1:0]  BOOT_LAST  = BOOT_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [REDIRECT_CNT_W-1:0] CNT_MAX = {REDIRECT_CNT_W{1'b1}};

    seq_state_e                state_q, state_d;
    logic [BOOT_CNT_W-1:0]     boot_cnt_q, boot_cnt_d;
    logic [STALL_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [REDIRECT_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic                      multi_err_q, multi_err_d;

    logic       br_taken;
    logic       commit;
    logic       redirect_ok;
    logic [3:0] req_vec;

    branch_cond_eval u_cond (
        .br_cond (bus.br_cond),
        .flag_z  (bus.flag_z),
        .flag_c  (bus.flag_c),
        .taken   (br_taken)
    );

    // A HALT commit advances the PC plainly, so redirects are only honoured without it.
    assign commit      = (state_q == RUN) && bus.imem_ready;
    assign redirect_ok = commit && !bus.halt_req;
    assign req_vec     = {bus.jr_req, bus.jal_rm_req, bus.jmp_req, bus.br_req & br_taken};

    // State and counter registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q        <= BOOT;
            boot_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
            multi_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            boot_cnt_q     <= boot_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
            multi_err_q    <= multi_err_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        multi_err_d    = multi_err_q;

        case (state_q)
            BOOT: begin
                boot_cnt_d  = boot_cnt_q + {{(BOOT_CNT_W-1){1'b0}}, 1'b1};
                stall_cnt_d = '0;
                if (boot_cnt_q >= BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = BOOT;
                end
            end
            RUN: begin
                if (bus.imem_ready) begin
                    stall_cnt_d = '0;
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
                    if (stall_cnt_q >= STALL_LAST) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                stall_cnt_d = '0;
                if (bus.resume) begin
                    state_d = RUN;
                end else begin
                    state_d = HALT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (redirect_ok && (req_vec != 4'd0) && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + {{(REDIRECT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end

        if (redirect_ok && multi_hot4(req_vec)) begin
            multi_err_d = 1'b1;
        end else begin
            multi_err_d = multi_err_q;
        end
    end

    // PC enable and one-hot source select for the current cycle.
    always_comb begin
        bus.PC_EN       = 1'b0;
        bus.PC_SE_flag  = 1'b0;
        bus.JMP_flag    = 1'b0;
        bus.JAL_Rm_flag = 1'b0;
        bus.JR_flag     = 1'b0;

        if (commit) begin
            bus.PC_EN = 1'b1;
        end else begin
            bus.PC_EN = 1'b0;
        end

        if (redirect_ok) begin
            if (req_vec[3]) begin
                bus.JR_flag = 1'b1;
            end else if (req_vec[2]) begin
                bus.JAL_Rm_flag = 1'b1;
            end else if (req_vec[1]) begin
                bus.JMP_flag = 1'b1;
            end else if (req_vec[0]) begin
                bus.PC_SE_flag = 1'b1;
            end else begin
                bus.PC_SE_flag = 1'b0;
            end
        end else begin
            bus.JR_flag = 1'b0;
        end
    end

    assign bus.halted        = (state_q == HALT);
    assign bus.fault         = (state_q == FAULT);
    assign bus.multi_req_err = multi_err_q;
    assign bus.redirect_cnt  = redirect_cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: boot timing, branch conditions, priority,
// halt/resume, stall watchdog, counter saturation and clear.
module tb_pc_seq_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl_if bus ();

    pc_seq_ctrl #(
        .BOOT_CYCLES   (2),
        .STALL_TIMEOUT (15)
    ) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.br_req = 1'b0; bus.br_cond = 3'd0; bus.flag_z = 1'b0; bus.flag_c = 1'b0;
        bus.jmp_req = 1'b0; bus.jal_rm_req = 1'b0; bus.jr_req = 1'b0;
        bus.halt_req = 1'b0; bus.resume = 1'b0;
    endtask

    // {PC_EN, PC_SE, JMP, JAL_Rm, JR}
    function automatic logic [4:0] strobes();
        return {bus.PC_EN, bus.PC_SE_flag, bus.JMP_flag, bus.JAL_Rm_flag, bus.JR_flag};
    endfunction

    function automatic logic [23:0] all_outs();
        return {strobes(), bus.halted, bus.fault, bus.multi_req_err, bus.redirect_cnt};
    endfunction

    initial begin
        idle();
        bus.imem_ready = 1'b1;

        // Reset and boot
        clr = 1'b1; tick(); clr = 1'b0; #1;
        chk("boot0_all_zero", all_outs(), 24'h0);
        tick(); #1;
        chk("boot1_all_zero", all_outs(), 24'h0);
        tick(); #1;
        chk("run_first_pc_en", strobes(), 5'b10000);
        tick();
        chk("cnt_after_plain", bus.redirect_cnt, 16'd0);

        // BEQ taken
        bus.br_req = 1'b1; bus.br_cond = 3'd0; bus.flag_z = 1'b1; #1;
        chk("beq_taken", strobes(), 5'b11000);
        tick();
        chk("cnt_beq", bus.redirect_cnt, 16'd1);
        // BEQ not taken
        bus.flag_z = 1'b0; #1;
        chk("beq_not_taken", strobes(), 5'b10000);
        tick();
        chk("cnt_beq_nt", bus.redirect_cnt, 16'd1);
        // Code 6 never taken
        bus.br_cond = 3'd6; bus.flag_z = 1'b1; bus.flag_c = 1'b1; #1;
        chk("cond6_never", strobes(), 5'b10000);
        tick();
        // BNE with Z=0 taken
        bus.br_cond = 3'd1; bus.flag_z = 1'b0; #1;
        chk("bne_taken", strobes(), 5'b11000);
        tick();
        // BCC with C=1 not taken
        bus.br_cond = 3'd3; bus.flag_c = 1'b1; #1;
        chk("bcc_not_taken", strobes(), 5'b10000);
        tick();
        // BCS with C=1 taken
        bus.br_cond = 3'd2; #1;
        chk("bcs_taken", strobes(), 5'b11000);
        tick();
        chk("cnt_after_branches", bus.redirect_cnt, 16'd3);
        // JAL Rm alone
        idle(); bus.jal_rm_req = 1'b1; #1;
        chk("jal_rm", strobes(), 5'b10010);
        tick();
        chk("cnt_jal", bus.redirect_cnt, 16'd4);
        chk("no_multi_yet", bus.multi_req_err, 1'b0);

        // JR + JMP + BAL
        idle(); bus.jr_req = 1'b1; bus.jmp_req = 1'b1; bus.br_req = 1'b1; bus.br_cond = 3'd4; #1;
        chk("prio_jr", strobes(), 5'b10001);
        tick();
        idle(); #1;
        chk("multi_set", bus.multi_req_err, 1'b1);
        chk("cnt_prio", bus.redirect_cnt, 16'd5);
        tick();
        chk("multi_sticky", bus.multi_req_err, 1'b1);

        // JAL Rm beats JMP
        bus.jal_rm_req = 1'b1; bus.jmp_req = 1'b1; #1;
        chk("prio_jal_over_jmp", strobes(), 5'b10010);
        tick();
        idle(); #1;
        chk("cnt_jal_jmp", bus.redirect_cnt, 16'd6);

        // Halt with JMP ignored
        bus.halt_req = 1'b1; bus.jmp_req = 1'b1; #1;
        chk("halt_commit", strobes(), 5'b10000);
        tick();
        idle(); #1;
        chk("halted", bus.halted, 1'b1);
        chk("halt_pc_en", strobes(), 5'b00000);
        chk("cnt_halt", bus.redirect_cnt, 16'd6);
        tick();
        chk("still_halted", bus.halted, 1'b1);
        bus.resume = 1'b1; #1;
        chk("halted_resume_cycle", bus.halted, 1'b1);
        tick();
        bus.resume = 1'b0; #1;
        chk("resumed", {bus.halted, strobes()}, 6'b010000);

        // 14 stall cycles: no fault
        bus.imem_ready = 1'b0; bus.jmp_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk("stall14_pc_en", strobes(), 5'b00000);
            tick();
        end
        bus.imem_ready = 1'b1; bus.jmp_req = 1'b0; #1;
        chk("stall14_no_fault", {bus.fault, strobes()}, 6'b010000);
        chk("cnt_stall", bus.redirect_cnt, 16'd6);
        tick();

        // 15 stall cycles: fault
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #1;
        chk("stall15_last_run", bus.fault, 1'b0);
        tick();
        bus.imem_ready = 1'b1; bus.resume = 1'b1; bus.jr_req = 1'b1; #1;
        chk("fault_set", {bus.fault, strobes()}, 6'b100000);
        tick(); tick(); #1;
        chk("fault_persists", {bus.fault, strobes()}, 6'b100000);
        idle();

        // Clear out of FAULT
        clr = 1'b1; tick(); clr = 1'b0; #1;
        chk("clr_from_fault", all_outs(), 24'h0);
        tick(); tick();

        // Saturate redirect counter
        bus.jmp_req = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("cnt_fffe", bus.redirect_cnt, 16'hFFFE);
        tick();
        chk("cnt_ffff", bus.redirect_cnt, 16'hFFFF);
        #1;
        chk("jmp_at_sat", strobes(), 5'b10100);
        tick();
        chk("cnt_hold", bus.redirect_cnt, 16'hFFFF);

        // Set multi error, then CLR mid-RUN with JR pending
        bus.jr_req = 1'b1; tick();
        bus.jmp_req = 1'b0; #1;
        chk("multi_before_clr", bus.multi_req_err, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0; #1;
        chk("clr_mid_run", all_outs(), 24'h0);
        idle(); #1;
        chk("clr_boot_pc_en", bus.PC_EN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
